// File: rtl/uart_tx_fifo_sched.sv
// Drains the TX FIFO one byte at a time into the UART shift engine; start lasts until busy rises.
// Latency: !fifo_empty in IDLE -> rdreq next cycle -> tx_start two cycles later; ack timeout drops the byte.
module uart_tx_fifo_sched #(
  parameter int DATA_W      = 8,
  parameter int USEDW_W     = 4,
  parameter int THRESH      = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               sclr,
  input  logic               tx_en,
  input  logic               flush,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               fifo_rdreq,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               irq_txlow,
  output logic               ack_err,
  output logic               sched_busy,
  output logic [15:0]        sent_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WACK  = 3'd3;
  localparam logic [2:0] S_WDONE = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  localparam logic [15:0]        TO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [USEDW_W:0]   THRESH_L = (USEDW_W+1)'(THRESH);
  localparam logic [USEDW_W:0]   FULL_L   = (USEDW_W+1)'(2**USEDW_W);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             flush_pend;
  logic [15:0]      to_cnt;
  logic [15:0]      cnt_q;
  logic [USEDW_W:0] fill_lvl;
  logic             accept;
  logic             timeout;

  // usedw wraps to 0 when full, so the full flag supplies the missing top value
  assign fill_lvl = fifo_full ? FULL_L : {1'b0, fifo_usedw};

  assign accept  = (state == S_WACK) && tx_busy;
  assign timeout = (state == S_WACK) && !tx_busy && (to_cnt == TO_LAST);

  assign fifo_rdreq = (state == S_POP) || ((state == S_FLUSH) && !fifo_empty);
  assign tx_start   = (state == S_WACK);
  assign sched_busy = (state != S_IDLE);
  assign sent_cnt   = cnt_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (flush_pend)
          state_nxt = S_FLUSH;
        else if (tx_en && !fifo_empty)
          state_nxt = S_POP;
      end
      S_POP:   state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WACK;
      S_WACK: begin
        if (tx_busy)
          state_nxt = S_WDONE;
        else if (timeout)
          state_nxt = S_IDLE;
      end
      S_WDONE: begin
        if (!tx_busy)
          state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        if (fifo_empty)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state      <= S_IDLE;
      tx_data    <= '0;
      irq_txlow  <= 1'b0;
      ack_err    <= 1'b0;
      cnt_q      <= '0;
      flush_pend <= 1'b0;
      to_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      irq_txlow <= tx_en && (fill_lvl <= THRESH_L);
      // a flush request arriving on the exit cycle must survive for the next pass
      if (flush)
        flush_pend <= 1'b1;
      else if ((state == S_FLUSH) && fifo_empty)
        flush_pend <= 1'b0;
      if (state == S_LOAD)
        tx_data <= fifo_q;
      if (state == S_LOAD)
        to_cnt <= '0;
      else if ((state == S_WACK) && (to_cnt != 16'hFFFF))
        to_cnt <= to_cnt + 16'd1;
      if (timeout)
        ack_err <= 1'b1;
      cnt_q <= cnt_q + {15'd0, accept};
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Bench for uart_tx_fifo_sched: queue FIFO model, delayed-busy transmitter and byte scoreboard.
module tb_uart_tx_fifo_sched;

  localparam int THRESH = 4;

  logic        clock = 1'b0;
  logic        sclr = 1'b1;
  logic        tx_en = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_usedw;
  logic [7:0]  fifo_q;
  logic        fifo_rdreq;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        irq_txlow;
  logic        ack_err;
  logic        sched_busy;
  logic [15:0] sent_cnt;

  uart_tx_fifo_sched #(
    .DATA_W(8), .USEDW_W(4), .THRESH(THRESH), .ACK_TIMEOUT(8)
  ) dut (
    .clock(clock), .sclr(sclr), .tx_en(tx_en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .irq_txlow(irq_txlow),
    .ack_err(ack_err), .sched_busy(sched_busy), .sent_cnt(sent_cnt)
  );

  always #5 clock = ~clock;

  // FIFO: 16 entries, read data registered one cycle after rdreq
  logic       wr_en = 1'b0;
  logic [7:0] wr_dat = 8'h00;
  logic [7:0] mem [16];
  int         rp = 0;
  int         wp = 0;
  int         fill = 0;
  logic [7:0] q_r = 8'h00;

  assign fifo_empty = (fill == 0);
  assign fifo_full  = (fill == 16);
  assign fifo_usedw = 4'(fill);
  assign fifo_q     = q_r;

  always @(posedge clock) begin
    if (fifo_rdreq && fill > 0) begin
      q_r <= mem[rp];
      rp  <= (rp + 1) % 16;
    end
    if (wr_en && fill < 16) begin
      mem[wp] <= wr_dat;
      wp      <= (wp + 1) % 16;
    end
    fill <= fill + ((wr_en && fill < 16) ? 1 : 0) - ((fifo_rdreq && fill > 0) ? 1 : 0);
  end

  // transmitter: busy rises ack_dly cycles after start is seen, stays high busy_len cycles
  logic ack_en = 1'b1;
  int   ack_dly = 2;
  int   busy_len = 10;
  int   dly_cnt = 0;
  int   blen_cnt = 0;

  always @(posedge clock) begin
    if (tx_busy) begin
      dly_cnt <= 0;
      if (blen_cnt <= 1) tx_busy <= 1'b0;
      else blen_cnt <= blen_cnt - 1;
    end else if (tx_start && ack_en) begin
      if (dly_cnt + 1 >= ack_dly) begin
        tx_busy  <= 1'b1;
        blen_cnt <= busy_len;
        dly_cnt  <= 0;
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else begin
      dly_cnt <= 0;
    end
  end

  // observation: accepted bytes, read pulses, start rises, irq expectation from fill level
  logic [7:0] sent_q [$];
  int   rdreq_cnt = 0;
  int   rd_empty_err = 0;
  int   start_rise = 0;
  logic start_d = 1'b0;
  logic exp_irq = 1'b0;
  logic chk_on = 1'b0;
  int   irq_chk = 0;
  int   irq_err = 0;

  always @(posedge clock) begin
    if (!sclr && tx_start && tx_busy) sent_q.push_back(tx_data);
    if (fifo_rdreq) rdreq_cnt <= rdreq_cnt + 1;
    if (fifo_rdreq && fifo_empty) rd_empty_err <= rd_empty_err + 1;
    if (tx_start && !start_d) start_rise <= start_rise + 1;
    start_d <= tx_start;
    exp_irq <= !sclr && tx_en && (fill <= THRESH);
  end

  always @(negedge clock) begin
    if (chk_on) begin
      irq_chk <= irq_chk + 1;
      if (irq_txlow !== exp_irq) irq_err <= irq_err + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clock);
    wr_en  = 1'b1;
    wr_dat = b;
    @(posedge clock);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(fill == 0 && !sched_busy && !tx_busy) && n < 3000);
    check({tag, "_idle_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_start_timeout"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int base_s, base_r, base_c, base_st, n, hi, bad;
    logic [7:0] bytes [16];

    repeat (3) @(negedge clock);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_outputs", {27'd0, fifo_rdreq, tx_start, sched_busy, irq_txlow, ack_err}, 32'h0);
    check("rst_sent_cnt", 32'(sent_cnt), 32'h0);
    sclr = 1'b0;
    chk_on = 1'b1;

    // two bytes, exact pop/start latency and ordering
    ack_dly = 2; busy_len = 10;
    push(8'h55);
    push(8'hA3);
    @(negedge clock);
    tx_en = 1'b1;
    @(negedge clock);
    check("lat_rdreq", {30'd0, fifo_rdreq, tx_start}, 32'h2);
    @(negedge clock);
    check("lat_load", {30'd0, fifo_rdreq, tx_start}, 32'h0);
    @(negedge clock);
    check("lat_start", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'h55});
    wait_idle("t1");
    check("t1_nbytes", 32'(sent_q.size()), 32'd2);
    if (sent_q.size() >= 2) begin
      check("t1_byte0", 32'(sent_q[0]), 32'h55);
      check("t1_byte1", 32'(sent_q[1]), 32'hA3);
    end
    check("t1_sent_cnt", 32'(sent_cnt), 32'd2);
    check("t1_rdreq", 32'(rdreq_cnt), 32'd2);

    // full FIFO held with tx_en low, then drained past the watermark
    tx_en = 1'b0;
    ack_dly = 1; busy_len = 1;
    base_s = sent_q.size(); base_r = rdreq_cnt;
    for (int i = 0; i < 16; i++) begin
      bytes[i] = 8'($urandom);
      push(bytes[i]);
    end
    repeat (3) @(negedge clock);
    check("t2_full", {31'd0, fifo_full}, 32'd1);
    check("t2_irq_off", {31'd0, irq_txlow}, 32'd0);
    check("t2_no_rdreq", 32'(rdreq_cnt - base_r), 32'd0);
    tx_en = 1'b1;
    n = 0;
    while (irq_txlow !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("t2_irq_rise", 32'(n < 1000), 32'd1);
    check("t2_irq_level", 32'(fill <= THRESH && fill >= THRESH - 1), 32'd1);
    wait_idle("t2");
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (sent_q.size() <= base_s + i || sent_q[base_s + i] !== bytes[i]) bad++;
    check("t2_data", 32'(bad), 32'd0);
    check("t2_irq_empty", {31'd0, irq_txlow}, 32'd1);

    // flush while the first of five bytes is in flight
    tx_en = 1'b0;
    ack_dly = 1; busy_len = 10;
    for (int i = 0; i < 5; i++) begin
      bytes[i] = 8'($urandom);
      push(bytes[i]);
    end
    base_s = sent_q.size(); base_r = rdreq_cnt; base_c = int'(sent_cnt); base_st = start_rise;
    @(negedge clock);
    tx_en = 1'b1;
    n = 0;
    while (tx_busy !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t3_busy_seen", 32'(n < 200), 32'd1);
    repeat (2) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    wait_idle("t3");
    repeat (20) @(negedge clock);
    check("t3_nbytes", 32'(sent_q.size() - base_s), 32'd1);
    if (sent_q.size() > base_s) check("t3_byte0", 32'(sent_q[base_s]), 32'(bytes[0]));
    check("t3_rdreq", 32'(rdreq_cnt - base_r), 32'd5);
    check("t3_fill", 32'(fill), 32'd0);
    check("t3_sent_cnt", 32'(sent_cnt), 32'(base_c + 1));
    check("t3_starts", 32'(start_rise - base_st), 32'd1);

    // randomized bursts pushed while draining
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      ack_dly = $urandom_range(1, 3);
      busy_len = $urandom_range(1, 8);
      base_s = sent_q.size(); base_c = int'(sent_cnt);
      for (int i = 0; i < n; i++) begin
        bytes[i] = 8'($urandom);
        push(bytes[i]);
      end
      wait_idle("rnd");
      bad = 0;
      for (int i = 0; i < n; i++)
        if (sent_q.size() <= base_s + i || sent_q[base_s + i] !== bytes[i]) bad++;
      check("rnd_data", 32'(bad), 32'd0);
      check("rnd_count", 32'(sent_q.size() - base_s), 32'(n));
      check("rnd_sent_cnt", 32'(sent_cnt), 32'(16'(base_c + n)));
    end

    // transmitter never acknowledges the first byte
    tx_en = 1'b0; ack_en = 1'b0;
    ack_dly = 1; busy_len = 3;
    push(8'h11);
    push(8'h22);
    base_s = sent_q.size(); base_r = rdreq_cnt; base_c = int'(sent_cnt);
    @(negedge clock);
    tx_en = 1'b1;
    wait_start("t4");
    hi = 0;
    while (tx_start === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clock);
    end
    ack_en = 1'b1;
    check("t4_start_len", 32'(hi), 32'd8);
    check("t4_ack_err", {31'd0, ack_err}, 32'd1);
    check("t4_cnt_hold", 32'(sent_cnt), 32'(base_c));
    wait_idle("t4");
    check("t4_nbytes", 32'(sent_q.size() - base_s), 32'd1);
    if (sent_q.size() > base_s) check("t4_byte", 32'(sent_q[base_s]), 32'h22);
    check("t4_rdreq", 32'(rdreq_cnt - base_r), 32'd2);
    check("t4_err_sticky", {31'd0, ack_err}, 32'd1);

    // synchronous reset while waiting for acknowledge
    tx_en = 1'b0; ack_en = 1'b0;
    push(8'h33);
    push(8'h44);
    base_s = sent_q.size();
    @(negedge clock);
    tx_en = 1'b1;
    wait_start("t5");
    sclr = 1'b1;
    @(negedge clock);
    check("t5_tx_data", 32'(tx_data), 32'h0);
    check("t5_outputs", {27'd0, fifo_rdreq, tx_start, sched_busy, irq_txlow, ack_err}, 32'h0);
    check("t5_sent_cnt", 32'(sent_cnt), 32'h0);
    sclr = 1'b0; ack_en = 1'b1;
    wait_idle("t5");
    check("t5_nbytes", 32'(sent_q.size() - base_s), 32'd1);
    if (sent_q.size() > base_s) check("t5_byte", 32'(sent_q[base_s]), 32'h44);
    check("t5_cnt", 32'(sent_cnt), 32'd1);

    // counter wrap from a preset value near the top
    tx_en = 1'b0;
    ack_dly = 1; busy_len = 1;
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    @(negedge clock);
    force dut.cnt_q = 16'hFFFE;
    @(negedge clock);
    release dut.cnt_q;
    @(negedge clock);
    check("t6_preset", 32'(sent_cnt), 32'hFFFE);
    base_s = sent_q.size();
    tx_en = 1'b1;
    n = 0;
    while (sent_q.size() < base_s + 2 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("t6_wrap", 32'(sent_cnt), 32'h0000);
    wait_idle("t6");
    check("t6_after", 32'(sent_cnt), 32'h0001);

    check("irq_tracking", 32'(irq_err), 32'd0);
    check("irq_samples", 32'(irq_chk > 200), 32'd1);
    check("rdreq_when_empty", 32'(rd_empty_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
